dm_pipe: RTL and testbench
==========================

Name: dm_pipe

Overview:
- Parametrised successor to the single-cycle data memory: word-organised data RAM behind a valid/ready request port with a registered, configurable read latency.
- Correct big-endian byte/halfword lane selection from addr[1:0], misalignment and illegal-op detection, and a single-pulse response.
- Sits between the MEM stage and on-chip data RAM; the MEM stage stalls while req_ready is low or a response is pending.

Parameters:
- AW, 8, word-index width; depth NMEM = 2**AW words of 32 bits.
- RD_LAT, 1, read latency in cycles from accept edge to rsp_valid; legal 1..4.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  access type, encoded with the DM_OP_* macros from common.v (BS, BZ, HS, HZ, WD for loads; SB, SH, WD for stores)
- req_addr  in  32  byte address; bits [AW+1:2] index the word, upper bits ignored (wrap)
- req_wdata  in  32  store data, least-significant byte/halfword used for SB/SH
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal op, qualified by rsp_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 while rst_n low, 1 from the first clock after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not cleared (see optional feature).
- FSM states:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at the posedge.
  - WAIT: req_ready=0. Counter runs from RD_LAT-1 down to 0.
  - RESP: req_ready=0. rsp_valid=1 for exactly one cycle, then back to IDLE.
- Load: word read at the accept edge into a holding register. RESP is entered so that rsp_valid is high in cycle accept+RD_LAT. For RD_LAT=1, WAIT is skipped.
- Store:
  - Byte lanes are written at the accept edge; other lanes are unchanged.
  - RESP follows in the next cycle (latency 1, independent of RD_LAT) with rsp_rdata=0.
- Byte lanes are big-endian:
  - Byte offset 0 maps to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - Halfword with addr[1]=0 maps to [31:16]; addr[1]=1 maps to [15:0].
- Load extension: BS/HS sign-extend from the selected lane MSB; BZ/HZ zero-extend; WD passes the word through.
- Errors (rsp_err=1, rsp_rdata=0, no RAM write, normal response timing):
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load with a store-only op code, or store with a load-only op code;
  - any undefined code.
- Read-after-write: a load accepted the cycle after a store's RESP returns the new data. Only one request is outstanding, so no hazard exists.
- Throughput: loads take one request per RD_LAT+1 cycles; stores take one request per 2 cycles.
- Requests presented while req_ready=0 are ignored; the requester holds them.
- Reset mid-transaction: the pending response is dropped, no rsp_valid is produced, and a store already accepted stays written.

Optional Feature:
- Macro: DM_CLR_EN.
- Defined:
  - After reset release, a clear sequencer (state CLR) writes 0 to words 0..NMEM-1, one per cycle.
  - req_ready is held 0 during the sequence and rises in cycle NMEM after release.
  - Reset during CLR restarts the sequence from word 0.
- Undefined: no CLR state; req_ready=1 the first cycle after release and RAM powers up undefined.

Test Plan:
- Store WD 0x11223344 to addr 0x10, then load WD from 0x10 (RD_LAT=1) -> rsp_valid exactly 1 cycle after accept, rsp_rdata=0x11223344, rsp_err=0.
- After the above, load BS at 0x13, BZ at 0x12, HS at 0x12 (after SH 0x0000F0AA to 0x12):
  - BS at 0x13 -> rsp_rdata 0x00000044
  - BZ at 0x12 -> rsp_rdata 0x00000033
  - HS at 0x12 -> rsp_rdata 0xFFFFF0AA, and word 0x10 reads 0x1122F0AA
- SB 0x000000FF to 0x11 over word 0xAABBCCDD -> word becomes 0xAAFFCCDD.
- Misaligned LW at 0x0E, SH at 0x0B:
  - each gives rsp_err=1, rsp_rdata=0;
  - a following load shows memory unchanged.
- RD_LAT=3 build, back-to-back loads with req_valid held high:
  - req_ready low for 3 cycles after each accept;
  - rsp_valid at accept+3;
  - second accept exactly 4 cycles after the first.
- Assert rst_n=0 one cycle after a load accept with RD_LAT=3 -> rsp_valid never pulses and outputs read 0. With DM_CLR_EN and AW=4, req_ready rises 16 cycles after release and all words read 0.

Source files
------------

// File: rtl/dm_pipe.sv
// dm_pipe: word-organised data RAM behind a valid/ready request port.
//
// A request is accepted when req_valid && req_ready at a posedge. The RAM word
// is read (loads) or byte-lane written (stores) on that same accept edge.
// A single one-cycle rsp_valid pulse follows:
//   loads  : rsp_valid high RD_LAT cycles after the accept cycle
//   stores : rsp_valid high 1 cycle after the accept cycle
// Lanes are big-endian: byte offset 0 is [31:24] and offset 3 is [7:0].
// Halfword addr[1]=0 is [31:16].
// Misaligned accesses, wrong-direction op codes and undefined op codes return
// rsp_err=1 and rsp_rdata=0 with normal timing, and they never write the RAM.
//
// Parameters: AW     word-index width (NMEM = 2**AW words)
//             RD_LAT load latency, 1..4
// Ports: clk, rst_n (async active-low)
//        req_valid/req_ready/req_we/req_op/req_addr/req_wdata  request side
//        rsp_valid/rsp_rdata/rsp_err                           response side
// Optional feature macro DM_CLR_EN: after reset release, a clear sequencer
// zeroes every word (one per cycle) before the first request is accepted.
// DM_OP_* codes normally come from common.v. The defaults below are used only
// when common.v has not been included.

`ifndef DM_OP_BS
`define DM_OP_BS 3'd0
`endif
`ifndef DM_OP_BZ
`define DM_OP_BZ 3'd1
`endif
`ifndef DM_OP_HS
`define DM_OP_HS 3'd2
`endif
`ifndef DM_OP_HZ
`define DM_OP_HZ 3'd3
`endif
`ifndef DM_OP_WD
`define DM_OP_WD 3'd4
`endif
`ifndef DM_OP_SB
`define DM_OP_SB 3'd5
`endif
`ifndef DM_OP_SH
`define DM_OP_SH 3'd6
`endif

module dm_pipe #(
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int NMEM = 2 ** AW;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

`ifdef DM_CLR_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] hold_data;
    logic        hold_err;
    logic [31:0] mem [NMEM];

    logic [AW-1:0] widx;
    logic [1:0]    boff;
    logic [31:0]   word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic          op_err;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   res;
    logic          accept;
    logic          unused_addr;

    // Upper address bits are ignored, so the word index wraps.
    assign widx        = req_addr[AW+1:2];
    assign boff        = req_addr[1:0];
    assign unused_addr = ^req_addr[31:AW+2];
    assign word        = mem[widx];
    // Big-endian lane select: offset b lives at bit 8*(3-b). ~b equals 3-b.
    assign bsel        = word[{~boff, 3'b000} +: 8];
    assign hsel        = boff[1] ? word[15:0] : word[31:16];
    assign accept      = req_valid && req_ready;

    always_comb begin
        op_err = 1'b0;
        be     = 4'b0000;
        wd     = '0;
        res    = '0;
        if (req_we) begin
            case (req_op)
                `DM_OP_SB: begin
                    be = 4'b1000 >> boff;
                    wd = {4{req_wdata[7:0]}};
                end
                `DM_OP_SH: begin
                    if (boff[0]) op_err = 1'b1;
                    else         be = boff[1] ? 4'b0011 : 4'b1100;
                    wd = {2{req_wdata[15:0]}};
                end
                `DM_OP_WD: begin
                    if (boff != 2'd0) op_err = 1'b1;
                    else              be = 4'b1111;
                    wd = req_wdata;
                end
                default: op_err = 1'b1;
            endcase
        end else begin
            case (req_op)
                `DM_OP_BS: res = {{24{bsel[7]}}, bsel};
                `DM_OP_BZ: res = {24'd0, bsel};
                `DM_OP_HS: begin
                    if (boff[0]) op_err = 1'b1;
                    else         res = {{16{hsel[15]}}, hsel};
                end
                `DM_OP_HZ: begin
                    if (boff[0]) op_err = 1'b1;
                    else         res = {16'd0, hsel};
                end
                `DM_OP_WD: begin
                    if (boff != 2'd0) op_err = 1'b1;
                    else              res = word;
                end
                default: op_err = 1'b1;
            endcase
            if (op_err) res = '0;
        end
    end

`ifdef DM_CLR_EN
    logic [AW-1:0] clr_ptr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef DM_CLR_EN
            state   <= CLR;
            clr_ptr <= '0;
`else
            state   <= IDLE;
`endif
            req_ready <= 1'b0;
            cnt       <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        hold_data <= res;
                        hold_err  <= op_err;
                        // Stores respond next cycle regardless of RD_LAT.
                        if (req_we || RD_LAT == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= res;
                            rsp_err   <= op_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else begin
                        // This also raises ready on the first edge after reset.
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd1) begin
                        state     <= RESP;
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= hold_data;
                        rsp_err   <= hold_err;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
`ifdef DM_CLR_EN
                CLR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == AW'(NMEM - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // RAM is intentionally not reset.
    always_ff @(posedge clk) begin
`ifdef DM_CLR_EN
        if (state == CLR) mem[clr_ptr] <= '0;
        else
`endif
        if (accept && req_we && !op_err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dm_pipe.sv
// Self-checking bench for dm_pipe. There are two instances: k=0 uses RD_LAT=1
// and k=1 uses RD_LAT=3. Both share the clock and reset. Responses are checked
// against a byte-addressed big-endian memory model.
module tb_dm_pipe;
    localparam logic [2:0] BS = 3'd0, BZ = 3'd1, HS = 3'd2, HZ = 3'd3,
                           WD = 3'd4, SB = 3'd5, SH = 3'd6;
`ifdef DM_CLR_EN
    localparam int RDY_N = 256;
`else
    localparam int RDY_N = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rv, rr, rwe, rsv, rer;
    logic [1:0][2:0]  rop;
    logic [1:0][31:0] ra, rwd, rrd;

    dm_pipe #(.AW(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_we(rwe[0]), .req_op(rop[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
        .rsp_valid(rsv[0]), .rsp_rdata(rrd[0]), .rsp_err(rer[0]));

    dm_pipe #(.AW(8), .RD_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_we(rwe[1]), .req_op(rop[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
        .rsp_valid(rsv[1]), .rsp_rdata(rrd[1]), .rsp_err(rer[1]));

    int pass_n = 0;
    int total_n = 0;
    logic [7:0]  bm [2][1024];
    logic [31:0] got_d;
    logic        got_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: access size, direction legality, and alignment on a byte array.
    task automatic model(input int k, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] ed, output logic ee);
        int sz, ba;
        bit ld_ok, st_ok;
        logic [31:0] v;
        ld_ok = (op == BS || op == BZ || op == HS || op == HZ || op == WD);
        st_ok = (op == SB || op == SH || op == WD);
        sz = (op == BS || op == BZ || op == SB) ? 1 :
             (op == HS || op == HZ || op == SH) ? 2 : 4;
        ba = int'(addr % 1024);
        ee = !(we ? st_ok : ld_ok) || (ba % sz != 0);
        ed = '0;
        if (!ee) begin
            if (we) begin
                for (int i = 0; i < sz; i++) bm[k][ba+i] = 8'(wd >> (8 * (sz - 1 - i)));
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v = (v << 8) | 32'(bm[k][ba+i]);
                if (op == BS && v[7])  v = v | 32'hFFFF_FF00;
                if (op == HS && v[15]) v = v | 32'hFFFF_0000;
                ed = v;
            end
        end
    endtask

    task automatic xact(input int k, input bit we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag);
        logic [31:0] ed;
        logic ee;
        int n, lat;
        lat = (we || k == 0) ? 1 : 3;
        model(k, we, op, addr, wd, ed, ee);
        rv[k] = 1'b1; rwe[k] = we; rop[k] = op; ra[k] = addr; rwd[k] = wd;
        n = 0;
        while (!rr[k] && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, 32'(rr[k]), 32'd1);
        @(posedge clk); #1;
        rv[k] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsv[k] && n < 10);
        got_d = rrd[k];
        got_e = rer[k];
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_data"}, rrd[k], ed);
        chk({tag, "_err"}, 32'(rer[k]), 32'(ee));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rsv[k]), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_rdy"}, 32'(rr[k]), 32'd0);
            chk({tag, "_vld"}, 32'(rsv[k]), 32'd0);
            chk({tag, "_rdata"}, rrd[k], 32'd0);
            chk({tag, "_err"}, 32'(rer[k]), 32'd0);
        end
    endtask

    task automatic release_rst(input string tag);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rr[0] && n < 400);
        chk({tag, "_rdy_cycles"}, 32'(n), 32'(RDY_N));
        chk({tag, "_rdy3"}, 32'(rr[1]), 32'd1);
`ifdef DM_CLR_EN
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 1024; b++) bm[k][b] = 8'h00;
`endif
    endtask

    initial begin
        logic [31:0] ed, a;
        logic ee;
        logic [2:0] op;
        bit we;
        int k, n, acc[$], rsp[$];

        rv = '0; rwe = '0; rop = '0; ra = '0; rwd = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        release_rst("rel0");
`ifdef DM_CLR_EN
        xact(0, 0, WD, 32'h3FC, 0, "clr_ld0");
        xact(1, 0, WD, 32'h0, 0, "clr_ld1");
`endif
        for (int kk = 0; kk < 2; kk++)
            for (int w = 0; w < 256; w++) xact(kk, 1, WD, 32'(w * 4), $urandom, "init");

        // Directed steps on the RD_LAT=1 instance.
        xact(0, 1, WD, 32'h10, 32'h11223344, "st_wd");
        xact(0, 0, WD, 32'h10, 0, "ld_wd");   chk("ld_wd_const", got_d, 32'h11223344);
        xact(0, 0, BS, 32'h13, 0, "ld_bs");   chk("ld_bs_const", got_d, 32'h00000044);
        xact(0, 0, BZ, 32'h12, 0, "ld_bz");   chk("ld_bz_const", got_d, 32'h00000033);
        xact(0, 1, SH, 32'h12, 32'h0000F0AA, "st_sh");
        xact(0, 0, HS, 32'h12, 0, "ld_hs");   chk("ld_hs_const", got_d, 32'hFFFFF0AA);
        xact(0, 0, WD, 32'h10, 0, "ld_wd2");  chk("ld_wd2_const", got_d, 32'h1122F0AA);
        xact(0, 1, WD, 32'h10, 32'hAABBCCDD, "st_wd3");
        xact(0, 1, SB, 32'h11, 32'h000000FF, "st_sb");
        xact(0, 0, WD, 32'h10, 0, "ld_sb");   chk("ld_sb_const", got_d, 32'hAAFFCCDD);
        xact(0, 1, WD, 32'h0C, 32'h55667788, "st_0c");
        xact(0, 1, WD, 32'h08, 32'h01020304, "st_08");
        xact(0, 0, WD, 32'h0E, 0, "mis_lw");  chk("mis_lw_err", 32'(got_e), 32'd1);
        xact(0, 1, SH, 32'h0B, 32'h0000BEEF, "mis_sh"); chk("mis_sh_err", 32'(got_e), 32'd1);
        xact(0, 1, BZ, 32'h0C, 32'h12345678, "st_ldop");
        xact(0, 0, SB, 32'h0C, 0, "ld_stop");
        xact(0, 1, 3'd7, 32'h0C, 32'h12345678, "undef");
        xact(0, 0, WD, 32'h0C, 0, "unch_0c"); chk("unch_0c_const", got_d, 32'h55667788);
        xact(0, 0, WD, 32'h08, 0, "unch_08"); chk("unch_08_const", got_d, 32'h01020304);
        xact(1, 0, HZ, 32'h0C, 0, "lat3_hz");

        // Back-to-back loads on RD_LAT=3 with req_valid held high.
        model(1, 0, WD, 32'h10, 0, ed, ee);
        rv[1] = 1'b1; rwe[1] = 1'b0; rop[1] = WD; ra[1] = 32'h10;
        for (int i = 0; i < 10; i++) begin
            if (rr[1]) acc.push_back(i);
            if (rsv[1]) begin rsp.push_back(i); chk("b2b_data", rrd[1], ed); end
            @(negedge clk);
        end
        rv[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_acc_cnt", 32'(acc.size()), 32'd3);
        chk("b2b_gap", 32'(acc.size() >= 2 ? acc[1] - acc[0] : -1), 32'd4);
        chk("b2b_rsp_lat", 32'((acc.size() >= 1 && rsp.size() >= 1) ? rsp[0] - acc[0] : -1), 32'd3);
        chk("b2b_rsp_cnt", 32'(rsp.size()), 32'd2);

        // Reset one cycle after a RD_LAT=3 load is accepted.
        rv[1] = 1'b1; rwe[1] = 1'b0; rop[1] = WD; ra[1] = 32'h10;
        n = 0;
        while (!rr[1] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rv[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin #1; chk_idle("midrst"); @(negedge clk); end
        release_rst("rel1");

        // A store that was already accepted survives a reset during its response.
        model(1, 1, WD, 32'h40, 32'hCAFEF00D, ed, ee);
        rv[1] = 1'b1; rwe[1] = 1'b1; rop[1] = WD; ra[1] = 32'h40; rwd[1] = 32'hCAFEF00D;
        n = 0;
        while (!rr[1] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rv[1] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        release_rst("rel2");
        xact(1, 0, WD, 32'h40, 0, "st_kept");
`ifndef DM_CLR_EN
        chk("st_kept_const", got_d, 32'hCAFEF00D);
`endif

        // Random mix over both instances.
        for (int i = 0; i < 300; i++) begin
            k  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (op == BS || op == BZ || op == SB) ? a[1:0] :
                                                    (op == HS || op == HZ || op == SH) ? {a[1], 1'b0} : 2'b00;
            xact(k, we, op, a, $urandom, "rnd");
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
